// File: rtl/cnn_act_pkg.sv
// Shared encodings for the activation stream: activation modes and FSM states.
package cnn_act_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_LEAKY = 2'd2,
    MODE_CLAMP = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } act_state_e;

endpackage

// File: rtl/act_lane.sv
// Single-element activation: combinational f(x) for the selected mode plus the sign flag.
module act_lane
  import cnn_act_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_INT  = 6
) (
  input  logic [DATA_WIDTH-1:0] i_x,
  input  act_mode_e             i_mode,
  output logic [DATA_WIDTH-1:0] o_y,
  output logic                  o_neg
);

  localparam logic signed [DATA_WIDTH-1:0] CLAMP_MAX = DATA_WIDTH'(CLAMP_INT) <<< FRAC_BITS;

  logic signed [DATA_WIDTH-1:0] w_sx;
  logic signed [DATA_WIDTH-1:0] w_leak;

  assign w_sx   = $signed(i_x);
  assign w_leak = w_sx >>> LEAK_SHIFT;
  assign o_neg  = i_x[DATA_WIDTH-1];

  always_comb begin
    o_y = i_x;
    case (i_mode)
      MODE_RELU: begin
        if (o_neg) o_y = '0;
      end
      MODE_LEAKY: begin
        if (o_neg) o_y = w_leak;
      end
      MODE_CLAMP: begin
        if (o_neg) begin
          o_y = '0;
        end else if (w_sx > CLAMP_MAX) begin
          o_y = CLAMP_MAX;
        end
      end
      default: o_y = i_x;
    endcase
  end

endmodule

// File: rtl/activation_stream.sv
// Latches one FC neuron vector, applies the selected activation and streams it out LANES
// elements per beat under valid/ready, counting negative inputs along the way.
module activation_stream
  import cnn_act_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OUTPUT_NEURONS = 32,
  parameter int LANES          = 4,
  parameter int FRAC_BITS      = 16,
  parameter int LEAK_SHIFT     = 3,
  parameter int CLAMP_INT      = 6
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH*OUTPUT_NEURONS-1:0] output_fc,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*LANES-1:0]          out_data,
  output logic                                 out_last,
  output logic                                 done,
  output logic [$clog2(OUTPUT_NEURONS+1)-1:0]  neg_count
);

  localparam int BEATS      = OUTPUT_NEURONS / LANES;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W      = $clog2(OUTPUT_NEURONS + 1);
  localparam int LANE_CNT_W = $clog2(LANES + 1);
  localparam int BEAT_BITS  = DATA_WIDTH * LANES;

  if ((OUTPUT_NEURONS % LANES) != 0) begin : g_bad_cfg
    $error("activation_stream: OUTPUT_NEURONS must be a multiple of LANES");
  end

  act_state_e                           r_state, w_state_d;
  logic [DATA_WIDTH*OUTPUT_NEURONS-1:0] r_vec, w_vec_d;
  act_mode_e                            r_mode, w_mode_d;
  logic [BEAT_W-1:0]                    r_beat, w_beat_d;
  logic [BEAT_BITS-1:0]                 r_out_data, w_out_data_d;
  logic                                 r_out_valid, w_out_valid_d;
  logic                                 r_out_last, w_out_last_d;
  logic [CNT_W-1:0]                     r_neg_acc, w_neg_acc_d;
  logic [CNT_W-1:0]                     r_neg_count, w_neg_count_d;

  logic [BEAT_W-1:0]     w_beat_idx;
  logic                  w_is_last;
  logic [BEAT_BITS-1:0]  w_src;
  act_mode_e             w_mode_src;
  logic [BEAT_BITS-1:0]  w_act;
  logic [LANES-1:0]      w_neg;
  logic [LANE_CNT_W-1:0] w_beat_negs;
  logic                  w_load;

  // Beat 0 is computed straight from the input bus in IDLE so it is valid right after accept.
  assign w_beat_idx = (r_state == IDLE) ? '0 : r_beat;
  assign w_is_last  = (w_beat_idx == BEAT_W'(BEATS - 1));
  assign w_mode_src = (r_state == IDLE) ? act_mode_e'(mode) : r_mode;
  assign w_src      = (r_state == IDLE) ? output_fc[BEAT_BITS-1:0]
                                        : r_vec[int'(r_beat) * BEAT_BITS +: BEAT_BITS];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    act_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .LEAK_SHIFT(LEAK_SHIFT),
      .CLAMP_INT (CLAMP_INT)
    ) u_act_lane (
      .i_x   (w_src[j*DATA_WIDTH +: DATA_WIDTH]),
      .i_mode(w_mode_src),
      .o_y   (w_act[j*DATA_WIDTH +: DATA_WIDTH]),
      .o_neg (w_neg[j])
    );
  end

  always_comb begin
    w_beat_negs = '0;
    for (int j = 0; j < LANES; j++) begin
      w_beat_negs = w_beat_negs + LANE_CNT_W'(w_neg[j]);
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_vec_d       = r_vec;
    w_mode_d      = r_mode;
    w_beat_d      = r_beat;
    w_out_data_d  = r_out_data;
    w_out_valid_d = r_out_valid;
    w_out_last_d  = r_out_last;
    w_neg_acc_d   = r_neg_acc;
    w_neg_count_d = r_neg_count;
    w_load        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_vec_d     = output_fc;
          w_mode_d    = act_mode_e'(mode);
          w_neg_acc_d = CNT_W'(w_beat_negs);
          w_load      = 1'b1;
          w_state_d   = BUSY;
        end
      end
      BUSY: begin
        if (r_out_valid && out_ready && r_out_last) begin
          w_out_valid_d = 1'b0;
          w_out_last_d  = 1'b0;
          w_neg_count_d = r_neg_acc;
          w_state_d     = DONE;
        end else if (!r_out_valid || out_ready) begin
          w_neg_acc_d = r_neg_acc + CNT_W'(w_beat_negs);
          w_load      = 1'b1;
        end
      end
      DONE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase

    if (w_load) begin
      w_out_data_d  = w_act;
      w_out_valid_d = 1'b1;
      w_out_last_d  = w_is_last;
      w_beat_d      = w_is_last ? '0 : w_beat_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_vec       <= '0;
      r_mode      <= MODE_PASS;
      r_beat      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_neg_acc   <= '0;
      r_neg_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_vec       <= w_vec_d;
      r_mode      <= w_mode_d;
      r_beat      <= w_beat_d;
      r_out_data  <= w_out_data_d;
      r_out_valid <= w_out_valid_d;
      r_out_last  <= w_out_last_d;
      r_neg_acc   <= w_neg_acc_d;
      r_neg_count <= w_neg_count_d;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign done      = (r_state == DONE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign neg_count = r_neg_count;

endmodule

// File: tb/tb_activation_stream.sv
// Self-checking bench for activation_stream: fixed vectors, corner sequences and random vectors.
module tb_activation_stream;

  localparam int DW    = 32;
  localparam int N     = 32;
  localparam int L     = 4;
  localparam int B     = N / L;
  localparam longint CLAMP_V  = 6 * 65536;
  localparam longint LEAK_DIV = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      mode;
  logic            in_valid;
  logic            in_ready;
  logic [DW*N-1:0] output_fc;
  logic            out_valid;
  logic            out_ready;
  logic [DW*L-1:0] out_data;
  logic            out_last;
  logic            done;
  logic [5:0]      neg_count;

  int checks = 0;
  int failures = 0;
  logic [DW*L-1:0] rx_beats[B];
  int rx_n;

  activation_stream u_dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .output_fc(output_fc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done),
    .neg_count(neg_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  m;
    logic [31:0] x;
    logic [31:0] y;
    logic [5:0]  n;
  } vec_t;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference activation from the arithmetic definition (floor division for the leak).
  function automatic logic [31:0] model_act(input logic [1:0] m, input logic [31:0] x);
    longint v;
    longint q;
    v = longint'($signed(x));
    case (m)
      2'd1: return (v < 0) ? 32'd0 : x;
      2'd2: begin
        if (v < 0) begin
          q = -((-v + LEAK_DIV - 1) / LEAK_DIV);
          return q[31:0];
        end
        return x;
      end
      2'd3: begin
        if (v < 0) return 32'd0;
        if (v > CLAMP_V) return CLAMP_V[31:0];
        return x;
      end
      default: return x;
    endcase
  endfunction

  function automatic logic [DW*L-1:0] exp_beat(input logic [DW*N-1:0] v, input logic [1:0] m,
                                              input int b);
    logic [DW*L-1:0] r;
    for (int j = 0; j < L; j++) r[j*DW +: DW] = model_act(m, v[(b*L+j)*DW +: DW]);
    return r;
  endfunction

  function automatic int neg_model(input logic [DW*N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) if (v[i*DW + DW - 1]) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pat: 0 always ready, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_vec(input logic [DW*N-1:0] v, input logic [1:0] m, input int pat,
                         input logic chg, input logic [DW*N-1:0] v2, input logic [1:0] m2);
    int w = 0;
    int cyc = 0;
    logic rdy;
    logic prev_stall = 1'b0;
    logic [DW*L+1:0] prev_word = '0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    output_fc = v;
    mode      = m;
    in_valid  = 1'b1;
    tick();
    if (chg) begin
      output_fc = v2;
      mode      = m2;
    end else begin
      in_valid = 1'b0;
      mode     = ~m;
    end
    chk("first_beat_latency", out_valid, 1);
    rx_n = 0;
    while (!done && cyc < 200) begin
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, prev_word);
      chk("in_ready_busy", in_ready, 0);
      if (out_valid && rdy) begin
        if (rx_n < B) begin
          rx_beats[rx_n] = out_data;
          chk($sformatf("beat%0d_data", rx_n), out_data, exp_beat(v, m, rx_n));
          chk($sformatf("beat%0d_last", rx_n), out_last, (rx_n == B - 1));
        end
        rx_n++;
      end
      prev_stall = out_valid && !rdy;
      prev_word  = {out_valid, out_last, out_data};
      tick();
      cyc++;
    end
    chk("done_seen", done, 1);
    chk("beat_count", rx_n, B);
    chk("neg_count", neg_count, neg_model(v));
    chk("out_valid_in_done", out_valid, 0);
    chk("in_ready_in_done", in_ready, 0);
    if (pat == 0) chk("busy_cycles", cyc, B);
    out_ready = 1'b1;
    tick();
    chk("done_one_cycle", done, 0);
    chk("in_ready_after_done", in_ready, 1);
    chk("neg_count_stable", neg_count, neg_model(v));
  endtask

  vec_t tbl[12];
  logic [DW*N-1:0] v;
  logic [DW*N-1:0] v2;

  initial begin
    tbl[0]  = '{2'd2, 32'hFFFFFFF8, 32'hFFFFFFFF, 6'd1};
    tbl[1]  = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1};
    tbl[2]  = '{2'd2, 32'h80000000, 32'hF0000000, 6'd1};
    tbl[3]  = '{2'd2, 32'h00000005, 32'h00000005, 6'd0};
    tbl[4]  = '{2'd3, 32'h00050000, 32'h00050000, 6'd0};
    tbl[5]  = '{2'd3, 32'h00060000, 32'h00060000, 6'd0};
    tbl[6]  = '{2'd3, 32'h00060001, 32'h00060000, 6'd0};
    tbl[7]  = '{2'd3, 32'h7FFFFFFF, 32'h00060000, 6'd0};
    tbl[8]  = '{2'd3, 32'hFFFFFFFD, 32'h00000000, 6'd1};
    tbl[9]  = '{2'd1, 32'hFFFFFFFB, 32'h00000000, 6'd1};
    tbl[10] = '{2'd1, 32'h00000007, 32'h00000007, 6'd0};
    tbl[11] = '{2'd0, 32'h80000000, 32'h80000000, 6'd1};

    reset = 1'b1; mode = 2'd0; in_valid = 1'b0; output_fc = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_neg_count", neg_count, 0);
    chk("rst_out_data", out_data, 0);

    // ReLU on alternating +/- (i<<16).
    for (int i = 0; i < N; i++) v[i*DW +: DW] = (i % 2 == 0) ? (i << 16) : -(i << 16);
    run_vec(v, 2'd1, 0, 1'b0, '0, 2'd0);
    chk("relu_beat0_const", rx_beats[0], {32'h0, 32'h00020000, 32'h0, 32'h0});
    chk("relu_negcount_const", neg_count, 16);

    for (int t = 0; t < 12; t++) begin
      v = '0;
      v[31:0] = tbl[t].x;
      run_vec(v, tbl[t].m, 0, 1'b0, '0, 2'd0);
      chk($sformatf("tbl%0d_y", t), rx_beats[0][31:0], tbl[t].y);
      chk($sformatf("tbl%0d_neg", t), neg_count, tbl[t].n);
    end

    // Backpressure pattern.
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    run_vec(v, 2'd2, 1, 1'b0, '0, 2'd0);

    // Mode change plus in_valid while busy, then the held vector is accepted afterwards.
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    for (int i = 0; i < N; i++) v2[i*DW +: DW] = $urandom;
    run_vec(v, 2'd3, 0, 1'b1, v2, 2'd2);
    run_vec(v2, 2'd2, 0, 1'b0, '0, 2'd0);

    // Reset during beat 3.
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    output_fc = v; mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_reset_valid", out_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_quiet", {done, out_valid}, 2'b00);
    end
    for (int i = 0; i < N; i++) v[i*DW +: DW] = $urandom;
    run_vec(v, 2'd1, 0, 1'b0, '0, 2'd0);

    // Random vectors with a mix of special values and random ready.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0:       v[i*DW +: DW] = 32'h80000000;
          1:       v[i*DW +: DW] = 32'h00060000 + $urandom_range(0, 2) - 1;
          2:       v[i*DW +: DW] = -$urandom_range(1, 20);
          default: v[i*DW +: DW] = $urandom;
        endcase
      end
      run_vec(v, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'b0, '0, 2'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
